// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage between the register file and a
// variable-latency data memory, with a bounded ack wait and sticky timeout flag.
module load_store_unit #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          IsStore,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] StoreData,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic [DW-1:0] LoadData,
  output logic          LoadWriteEn,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, next_state;
  logic          is_store_q;
  logic          ok_q;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  // Saturating wait counter; the timeout fires on the edge it would reach TIMEOUT.
  always_comb begin
    cnt_inc     = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // Ack takes priority over a coincident timeout.
  always_comb begin
    next_state  = state;
    Busy        = (state != IDLE);
    MemReq      = 1'b0;
    MemWe       = 1'b0;
    Done        = 1'b0;
    LoadWriteEn = 1'b0;
    case (state)
      IDLE: begin
        if (Start) next_state = REQ;
      end
      REQ: begin
        MemReq = 1'b1;
        MemWe  = is_store_q;
        if (MemAck || timeout_hit) next_state = RESP;
      end
      RESP: begin
        Done        = 1'b1;
        LoadWriteEn = ok_q && !is_store_q;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      is_store_q <= 1'b0;
      ok_q       <= 1'b0;
      wait_cnt   <= '0;
      Error      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      LoadData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            is_store_q <= IsStore;
            MemAddr    <= Addr;
            MemWData   <= StoreData;
            Error      <= 1'b0;
            wait_cnt   <= '0;
            ok_q       <= 1'b0;
          end
        end
        REQ: begin
          if (MemAck) begin
            ok_q <= 1'b1;
            if (!is_store_q) LoadData <= MemRData;
          end else begin
            wait_cnt <= cnt_inc;
            if (timeout_hit) begin
              Error <= 1'b1;
              ok_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at
// Start and popped when Done is observed.
module tb_load_store_unit;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 15;

  logic          Clk, Reset, Start, IsStore, MemAck;
  logic [AW-1:0] Addr;
  logic [DW-1:0] StoreData, MemRData;
  logic          Busy, Done, Error, LoadWriteEn, MemReq, MemWe;
  logic [DW-1:0] LoadData, MemWData;
  logic [AW-1:0] MemAddr;

  typedef struct {
    logic [DW-1:0] ld;
    bit            lwe;
    bit            err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  load_store_unit #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IsStore(IsStore), .Addr(Addr),
    .StoreData(StoreData), .Busy(Busy), .Done(Done), .Error(Error),
    .LoadData(LoadData), .LoadWriteEn(LoadWriteEn), .MemReq(MemReq),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] ld, input bit lwe, input bit err);
    exp_t e;
    e.ld = ld; e.lwe = lwe; e.err = err;
    sbq.push_back(e);
  endtask

  // Drives one transaction, acking in REQ cycle number ack_after (-1 = never),
  // and reports what was observed; callers do the comparisons.
  task automatic run_access(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] rd, input int ack_after,
                            output int reqc, output bit stable, output bit done_seen,
                            output logic [DW-1:0] ld, output bit lwe, output bit err,
                            output bit err_at_start, output bit pulse_ok);
    Start = 1'b1; IsStore = st; Addr = a; StoreData = wd;
    tick();
    Start = 1'b0; IsStore = 1'b0; Addr = '0; StoreData = '0;
    err_at_start = Error;
    reqc = 0; stable = 1'b1; done_seen = 1'b0; ld = '0; lwe = 1'b0; err = 1'b0; pulse_ok = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      if (MemReq === 1'b1) begin
        if (MemWe !== st || MemAddr !== a || MemWData !== wd) stable = 1'b0;
        if (reqc == ack_after) begin
          MemAck = 1'b1; MemRData = rd;
        end
        reqc++;
      end
      tick();
      MemAck = 1'b0; MemRData = 16'hDEAD;
      if (Done === 1'b1) begin
        done_seen = 1'b1; ld = LoadData; lwe = LoadWriteEn; err = Error;
      end
    end
    if (done_seen) begin
      tick();
      pulse_ok = (Done === 1'b0 && LoadWriteEn === 1'b0 && Busy === 1'b0);
    end
  endtask

  task automatic test_reset();
    int reqc; bit stable, dn, lwe, err, e0, pok; logic [DW-1:0] ld; exp_t e;
    Reset = 1'b0; Start = 1'b0; IsStore = 1'b0; Addr = '0; StoreData = '0;
    MemAck = 1'b0; MemRData = '0;
    tick(); tick();
    checks++;
    if ({Busy, Done, Error, LoadWriteEn, MemReq, MemWe} !== 6'b0)
      begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {Busy, Done, Error, LoadWriteEn, MemReq, MemWe}); end
    checks++;
    if ({MemAddr, MemWData, LoadData} !== 48'h0)
      begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", {MemAddr, MemWData, LoadData}); end
    Reset = 1'b1;
    tick();
    Start = 1'b1; Addr = 16'h0077;
    tick();
    Start = 1'b0;
    tick();
    checks++;
    if (MemReq !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_req: got %b expected 1", MemReq); end
    Reset = 1'b0;
    #2;
    checks++;
    if ({MemReq, Busy, Done} !== 3'b000)
      begin errors++; $display("[TB] FAIL async_reset: got %b expected 000", {MemReq, Busy, Done}); end
    tick();
    Reset = 1'b1;
    tick();
    push_exp(16'h0C0C, 1'b1, 1'b0);
    run_access(1'b0, 16'h0008, 16'h0, 16'h0C0C, 1, reqc, stable, dn, ld, lwe, err, e0, pok);
    e = sbq.pop_front();
    checks++;
    if (!dn || ld !== e.ld || lwe !== e.lwe || err !== e.err)
      begin errors++; $display("[TB] FAIL post_reset_load: got done=%b ld=%h lwe=%b err=%b expected ld=%h lwe=%b err=%b", dn, ld, lwe, err, e.ld, e.lwe, e.err); end
  endtask

  task automatic test_load();
    int reqc; bit stable, dn, lwe, err, e0, pok; logic [DW-1:0] ld; exp_t e;
    push_exp(16'hBEEF, 1'b1, 1'b0);
    run_access(1'b0, 16'h0040, 16'h0, 16'hBEEF, 0, reqc, stable, dn, ld, lwe, err, e0, pok);
    e = sbq.pop_front();
    checks++;
    if (!dn || ld !== e.ld || lwe !== e.lwe || err !== e.err)
      begin errors++; $display("[TB] FAIL load_result: got done=%b ld=%h lwe=%b err=%b expected ld=%h lwe=%b err=%b", dn, ld, lwe, err, e.ld, e.lwe, e.err); end
    checks++;
    if (reqc != 1) begin errors++; $display("[TB] FAIL load_latency: got %0d req cycles expected 1", reqc); end
    checks++;
    if (!stable || !pok) begin errors++; $display("[TB] FAIL load_bus: got stable=%b pulse=%b expected 1 1", stable, pok); end
  endtask

  task automatic test_store();
    int reqc; bit stable, dn, lwe, err, e0, pok; logic [DW-1:0] ld; exp_t e;
    push_exp(16'hBEEF, 1'b0, 1'b0);
    run_access(1'b1, 16'h0012, 16'h1234, 16'h9999, 3, reqc, stable, dn, ld, lwe, err, e0, pok);
    e = sbq.pop_front();
    checks++;
    if (!dn || ld !== e.ld || lwe !== e.lwe || err !== e.err)
      begin errors++; $display("[TB] FAIL store_result: got done=%b ld=%h lwe=%b err=%b expected ld=%h lwe=%b err=%b", dn, ld, lwe, err, e.ld, e.lwe, e.err); end
    checks++;
    if (reqc != 4 || !stable)
      begin errors++; $display("[TB] FAIL store_bus: got %0d cycles stable=%b expected 4 cycles stable=1", reqc, stable); end
  endtask

  task automatic test_timeout();
    int reqc; bit stable, dn, lwe, err, e0, pok; logic [DW-1:0] ld; exp_t e;
    push_exp(16'hBEEF, 1'b0, 1'b1);
    run_access(1'b0, 16'h0300, 16'h0, 16'h4444, -1, reqc, stable, dn, ld, lwe, err, e0, pok);
    e = sbq.pop_front();
    checks++;
    if (!dn || ld !== e.ld || lwe !== e.lwe || err !== e.err)
      begin errors++; $display("[TB] FAIL timeout_result: got done=%b ld=%h lwe=%b err=%b expected ld=%h lwe=%b err=%b", dn, ld, lwe, err, e.ld, e.lwe, e.err); end
    checks++;
    if (reqc != TO) begin errors++; $display("[TB] FAIL timeout_len: got %0d req cycles expected %0d", reqc, TO); end
    checks++;
    if (Error !== 1'b1) begin errors++; $display("[TB] FAIL error_sticky: got %b expected 1", Error); end
  endtask

  task automatic test_ack_at_timeout();
    int reqc; bit stable, dn, lwe, err, e0, pok; logic [DW-1:0] ld; exp_t e;
    push_exp(16'h00A5, 1'b1, 1'b0);
    run_access(1'b0, 16'h0310, 16'h0, 16'h00A5, TO - 1, reqc, stable, dn, ld, lwe, err, e0, pok);
    e = sbq.pop_front();
    checks++;
    if (e0 !== 1'b0) begin errors++; $display("[TB] FAIL error_clear: got %b expected 0", e0); end
    checks++;
    if (!dn || ld !== e.ld || lwe !== e.lwe || err !== e.err)
      begin errors++; $display("[TB] FAIL ack_at_timeout: got done=%b ld=%h lwe=%b err=%b expected ld=%h lwe=%b err=%b", dn, ld, lwe, err, e.ld, e.lwe, e.err); end
    checks++;
    if (reqc != TO) begin errors++; $display("[TB] FAIL ack_at_timeout_len: got %0d expected %0d", reqc, TO); end
  endtask

  task automatic test_ignore_start();
    exp_t e; logic [DW-1:0] ld; bit dn, lwe;
    push_exp(16'h5A5A, 1'b1, 1'b0);
    Start = 1'b1; IsStore = 1'b0; Addr = 16'h0100;
    tick();
    Start = 1'b1; IsStore = 1'b1; Addr = 16'h0200;
    tick();
    Start = 1'b0; IsStore = 1'b0;
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 16'h0100 || MemWe !== 1'b0 || Busy !== 1'b1)
      begin errors++; $display("[TB] FAIL start_in_req: got req=%b addr=%h we=%b busy=%b expected 1 0100 0 1", MemReq, MemAddr, MemWe, Busy); end
    MemAck = 1'b1; MemRData = 16'h5A5A;
    tick();
    MemAck = 1'b0; MemRData = 16'hDEAD;
    dn = Done; ld = LoadData; lwe = LoadWriteEn;
    e = sbq.pop_front();
    checks++;
    if (dn !== 1'b1 || ld !== e.ld || lwe !== e.lwe)
      begin errors++; $display("[TB] FAIL ignore_result: got done=%b ld=%h lwe=%b expected 1 %h %b", dn, ld, lwe, e.ld, e.lwe); end
    Start = 1'b1; IsStore = 1'b1;
    tick();
    Start = 1'b0; IsStore = 1'b0;
    checks++;
    if (Busy !== 1'b0 || MemReq !== 1'b0)
      begin errors++; $display("[TB] FAIL start_in_resp: got busy=%b req=%b expected 0 0", Busy, MemReq); end
    MemAck = 1'b1; MemRData = 16'h7777;
    tick();
    MemAck = 1'b0;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || LoadData !== 16'h5A5A)
      begin errors++; $display("[TB] FAIL late_ack: got done=%b busy=%b ld=%h expected 0 0 5a5a", Done, Busy, LoadData); end
  endtask

  task automatic test_back_to_back();
    int dones, idles; exp_t e; bit bad;
    dones = 0; idles = 0; bad = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(16'h1111, 1'b1, 1'b0);
    Start = 1'b1; IsStore = 1'b0; Addr = 16'h0400; MemAck = 1'b1; MemRData = 16'h1111;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) Start = 1'b0;
      tick();
      if (Busy === 1'b0) idles++;
      if (Done === 1'b1) begin
        dones++;
        if (sbq.size() == 0) bad = 1'b1;
        else begin
          e = sbq.pop_front();
          if (LoadData !== e.ld || LoadWriteEn !== e.lwe) bad = 1'b1;
        end
      end
    end
    MemAck = 1'b0;
    checks++;
    if (dones != 3 || bad)
      begin errors++; $display("[TB] FAIL back_to_back: got %0d dones bad=%b expected 3 dones bad=0", dones, bad); end
    checks++;
    if (idles != 3) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0d idle cycles expected 3", idles); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_ignore_start();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
